// File: rtl/shift_mix_addkey_stage_if.sv
// Handshake/bus bundle for the AES ShiftRows/MixColumns/AddRoundKey stage.
// Optional out_parity member is present only when SMA_PARITY_EN is defined.
interface shift_mix_addkey_stage_if #(
  parameter int RW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic           in_first;
  logic [127:0]   in_state;
  logic [127:0]   in_rkey;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_state;
  logic [RW-1:0]  out_round;
  logic           out_last;
  logic           round_err;
`ifdef SMA_PARITY_EN
  logic [15:0]    out_parity;

  modport slave (
    input  in_valid, in_first, in_state, in_rkey, out_ready,
    output in_ready, out_valid, out_state, out_round, out_last, round_err, out_parity
  );

  modport master (
    output in_valid, in_first, in_state, in_rkey, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_last, round_err, out_parity
  );
`else
  modport slave (
    input  in_valid, in_first, in_state, in_rkey, out_ready,
    output in_ready, out_valid, out_state, out_round, out_last, round_err
  );

  modport master (
    output in_valid, in_first, in_state, in_rkey, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_last, round_err
  );
`endif
endinterface

// File: rtl/shift_mix_addkey_stage.sv
// AES round back half: ShiftRows, MixColumns (skipped on round NR), AddRoundKey,
// registered behind valid/ready. Optional SMA_PARITY_EN adds per-byte even parity.
module shift_mix_addkey_stage #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_mix_addkey_stage_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_reg, state_next;
  logic [RW-1:0]  rnd_reg, rnd_next;
  logic [RW-1:0]  eff_round;
  logic           final_round;
  logic           accept;
  logic           err_next;

  logic           out_valid_reg;
  logic [127:0]   out_state_reg;
  logic [RW-1:0]  out_round_reg;
  logic           out_last_reg;
  logic           round_err_reg;

  logic [7:0]     sb [16];
  logic [7:0]     sr [16];
  logic [7:0]     mc [16];
  logic [7:0]     rb [16];
  logic [127:0]   result;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Single output register: a beat can enter whenever the slot is empty or draining.
  assign bus.in_ready = rst || !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !rst;

  // Byte k sits at row k%4, column k/4; ShiftRows rotates row r left by r.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int R = gi % 4;
      localparam int C = gi / 4;
      assign sb[gi] = bus.in_state[127-8*gi -: 8];
      assign sr[gi] = sb[R + 4*((C + R) % 4)];
      assign rb[gi] = (final_round ? sr[gi] : mc[gi]) ^ bus.in_rkey[127-8*gi -: 8];
      assign result[127-8*gi -: 8] = rb[gi];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[4*gi + 0];
      assign a1 = sr[4*gi + 1];
      assign a2 = sr[4*gi + 2];
      assign a3 = sr[4*gi + 3];
      assign mc[4*gi + 0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[4*gi + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[4*gi + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rnd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
    end
  end

  // A misframed beat is still processed, always as round 1.
  always_comb begin
    state_next  = state_reg;
    rnd_next    = rnd_reg;
    err_next    = 1'b0;
    eff_round   = bus.in_first ? RW'(1) : rnd_reg + RW'(1);
    final_round = (eff_round == RW'(NR));
    if (accept) begin
      case (state_reg)
        IDLE:    err_next = !bus.in_first;
        BUSY:    err_next = bus.in_first;
        default: err_next = 1'b0;
      endcase
      if (final_round) begin
        rnd_next   = '0;
        state_next = IDLE;
      end else begin
        rnd_next   = eff_round;
        state_next = BUSY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_state_reg <= '0;
      out_round_reg <= '0;
      out_last_reg  <= 1'b0;
      round_err_reg <= 1'b0;
    end else begin
      round_err_reg <= err_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_state_reg <= result;
        out_round_reg <= eff_round;
        out_last_reg  <= final_round;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_state = out_state_reg;
  assign bus.out_round = out_round_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.round_err = round_err_reg;

`ifdef SMA_PARITY_EN
  logic [15:0] par_next;
  logic [15:0] out_parity_reg;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_par
      assign par_next[gi] = ^rb[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity_reg <= '0;
    end else if (accept) begin
      out_parity_reg <= par_next;
    end
  end

  assign bus.out_parity = out_parity_reg;
`endif

endmodule

// File: tb/tb_shift_mix_addkey_stage.sv
// Self-checking bench for shift_mix_addkey_stage: directed FIPS-197 vectors plus
// randomized traffic against a matrix-level AES round model.
module tb_shift_mix_addkey_stage;

  localparam int NR = 10;
  localparam int RW = 4;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  shift_mix_addkey_stage_if #(.RW(RW)) bus ();

  shift_mix_addkey_stage #(.NR(NR), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the output register should hold, and the block position.
  int             model_rnd;
  logic           exp_valid;
  logic [127:0]   exp_state;
  logic [RW-1:0]  exp_round;
  logic           exp_last;
  logic           exp_err;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k,
                                               input bit last);
    logic [7:0]   st [4][4];
    logic [7:0]   sh [4][4];
    logic [7:0]   mx [4][4];
    logic [7:0]   coef [4];
    logic [127:0] res;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int b = 0; b < 16; b++) st[b % 4][b / 4] = s[127-8*b -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][c] = st[r][(c + r) % 4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (last) mx[r][c] = sh[r][c];
        else begin
          mx[r][c] = 8'h00;
          for (int i = 0; i < 4; i++) mx[r][c] = mx[r][c] ^ gmul(coef[(i - r + 4) % 4], sh[i][c]);
        end
      end
    res = '0;
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = mx[b % 4][b / 4] ^ k[127-8*b -: 8];
    return res;
  endfunction

  function automatic logic [15:0] byte_parity(input logic [127:0] s);
    logic [15:0] p;
    for (int b = 0; b < 16; b++) p[b] = ^s[127-8*b -: 8];
    return p;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_in(input bit v, input bit first, input logic [127:0] s, input logic [127:0] k);
    bus.in_valid = v;
    bus.in_first = first;
    bus.in_state = s;
    bus.in_rkey  = k;
  endtask

  // Advance one clock and update the reference; inputs must already be driven.
  task automatic tick();
    bit           rdy, acc, err;
    int           eff;
    logic [127:0] res;
    rdy = rst || !exp_valid || bus.out_ready;
    acc = !rst && bus.in_valid && rdy;
    eff = bus.in_first ? 1 : model_rnd + 1;
    err = (model_rnd == 0) ? !bus.in_first : bus.in_first;
    res = model_round(bus.in_state, bus.in_rkey, eff == NR);
    @(posedge clk);
    if (rst) begin
      model_rnd = 0;
      exp_valid = 1'b0;
      exp_state = '0;
      exp_round = '0;
      exp_last  = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_err = acc && err;
      if (acc) begin
        exp_valid = 1'b1;
        exp_state = res;
        exp_round = RW'(eff);
        exp_last  = (eff == NR);
        model_rnd = (eff == NR) ? 0 : eff;
        $display("[TB] beat t=%0t round=%0d first=%0b err=%0b", $time, eff, bus.in_first, err);
      end else if (bus.out_ready) begin
        exp_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    set_in(1'b0, 1'b0, '0, '0);
    #1;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests++;
    tick();
    tick();
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++;
    if (bus.out_state !== 128'h0) begin fails++; $display("FAIL reset_out_state got %h want 0", bus.out_state); end
    tests++;
    if (bus.out_round !== 4'd0) begin fails++; $display("FAIL reset_out_round got %0d want 0", bus.out_round); end
    tests++;
    if (bus.out_last !== 1'b0 || bus.round_err !== 1'b0) begin
      fails++; $display("FAIL reset_last_err got %b%b want 00", bus.out_last, bus.round_err);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_held got %b want 1", bus.in_ready); end
    tests++;
    rst = 1'b0;
  endtask

  task automatic test_fips_round1();
    apply_reset();
    set_in(1'b1, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605);
    tick();
    set_in(1'b0, 1'b0, '0, '0);
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL r1_valid got %b want 1", bus.out_valid); end
    tests++;
    if (bus.out_state !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      fails++; $display("FAIL r1_state got %h want a49c7ff2689f352b6b5bea43026a5049", bus.out_state);
    end
    tests++;
    if (bus.out_round !== 4'd1 || bus.out_last !== 1'b0 || bus.round_err !== 1'b0) begin
      fails++; $display("FAIL r1_flags got round=%0d last=%b err=%b want 1 0 0", bus.out_round, bus.out_last, bus.round_err);
    end
    tests++;
`ifdef SMA_PARITY_EN
    if (bus.out_parity[0] !== 1'b1 || bus.out_parity !== byte_parity(128'ha49c7ff2689f352b6b5bea43026a5049)) begin
      fails++; $display("FAIL r1_parity got %h want %h", bus.out_parity, byte_parity(128'ha49c7ff2689f352b6b5bea43026a5049));
    end
    tests++;
`endif
    tick();
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL r1_drain got %b want 0", bus.out_valid); end
    tests++;
  endtask

  task automatic test_final_round();
    apply_reset();
    for (int b = 1; b <= 9; b++) begin
      set_in(1'b1, b == 1, rand128(), rand128());
      tick();
      if (bus.out_round !== RW'(b) || bus.out_state !== exp_state || bus.round_err !== 1'b0 || bus.out_last !== 1'b0) begin
        fails++; $display("FAIL fin_beat%0d got round=%0d state=%h err=%b want round=%0d state=%h err=0",
                          b, bus.out_round, bus.out_state, bus.round_err, b, exp_state);
      end
      tests++;
    end
    set_in(1'b1, 1'b0, 128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    if (bus.out_state !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      fails++; $display("FAIL fin_state got %h want 3925841d02dc09fbdc118597196a0b32", bus.out_state);
    end
    tests++;
    if (bus.out_round !== 4'd10 || bus.out_last !== 1'b1) begin
      fails++; $display("FAIL fin_flags got round=%0d last=%b want 10 1", bus.out_round, bus.out_last);
    end
    tests++;
    set_in(1'b1, 1'b1, rand128(), rand128());
    tick();
    if (bus.round_err !== 1'b0 || bus.out_round !== 4'd1 || bus.out_last !== 1'b0) begin
      fails++; $display("FAIL fin_restart got err=%b round=%0d last=%b want 0 1 0", bus.round_err, bus.out_round, bus.out_last);
    end
    tests++;
    set_in(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    apply_reset();
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b1, rand128(), rand128());
    tick();
    held = exp_state;
    set_in(1'b1, 1'b0, rand128(), rand128());
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d got %b want 0", i, bus.in_ready); end
      tests++;
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_state !== held || bus.out_round !== 4'd1) begin
        fails++; $display("FAIL bp_hold%0d got v=%b state=%h round=%0d want 1 %h 1", i, bus.out_valid, bus.out_state, bus.out_round, held);
      end
      tests++;
    end
    bus.out_ready = 1'b1;
    for (int b = 2; b <= 4; b++) begin
      set_in(1'b1, 1'b0, rand128(), rand128());
      #1;
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready%0d got %b want 1", b, bus.in_ready); end
      tests++;
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_round !== RW'(b) || bus.out_state !== exp_state) begin
        fails++; $display("FAIL bp_stream%0d got v=%b round=%0d state=%h want 1 %0d %h", b, bus.out_valid, bus.out_round, bus.out_state, b, exp_state);
      end
      tests++;
    end
    set_in(1'b0, 1'b0, '0, '0);
    tick();
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
    tests++;
  endtask

  task automatic test_framing();
    apply_reset();
    set_in(1'b1, 1'b0, rand128(), rand128());
    tick();
    if (bus.round_err !== 1'b1 || bus.out_round !== 4'd1 || bus.out_state !== exp_state) begin
      fails++; $display("FAIL frm_idle got err=%b round=%0d state=%h want 1 1 %h", bus.round_err, bus.out_round, bus.out_state, exp_state);
    end
    tests++;
    for (int b = 2; b <= 4; b++) begin
      set_in(1'b1, 1'b0, rand128(), rand128());
      tick();
      if (bus.round_err !== 1'b0 || bus.out_round !== RW'(b)) begin
        fails++; $display("FAIL frm_seq%0d got err=%b round=%0d want 0 %0d", b, bus.round_err, bus.out_round, b);
      end
      tests++;
    end
    set_in(1'b1, 1'b1, rand128(), rand128());
    tick();
    if (bus.round_err !== 1'b1 || bus.out_round !== 4'd1 || bus.out_state !== exp_state) begin
      fails++; $display("FAIL frm_busy got err=%b round=%0d state=%h want 1 1 %h", bus.round_err, bus.out_round, bus.out_state, exp_state);
    end
    tests++;
    set_in(1'b0, 1'b0, '0, '0);
    tick();
    if (bus.round_err !== 1'b0) begin fails++; $display("FAIL frm_pulse got %b want 0", bus.round_err); end
    tests++;
  endtask

  task automatic test_reset_mid_block();
    apply_reset();
    for (int b = 1; b <= 5; b++) begin
      set_in(1'b1, b == 1, rand128(), rand128());
      tick();
    end
    if (bus.out_valid !== 1'b1 || bus.out_round !== 4'd5) begin
      fails++; $display("FAIL mid_pre got v=%b round=%0d want 1 5", bus.out_valid, bus.out_round);
    end
    tests++;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    set_in(1'b1, 1'b0, rand128(), rand128());
    #1;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", bus.in_ready); end
    tests++;
    tick();
    rst = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.out_round !== 4'd0) begin
      fails++; $display("FAIL mid_flush got v=%b round=%0d want 0 0", bus.out_valid, bus.out_round);
    end
    tests++;
    bus.out_ready = 1'b1;
    set_in(1'b1, 1'b1, rand128(), rand128());
    tick();
    if (bus.round_err !== 1'b0 || bus.out_round !== 4'd1 || bus.out_state !== exp_state) begin
      fails++; $display("FAIL mid_restart got err=%b round=%0d state=%h want 0 1 %h", bus.round_err, bus.out_round, bus.out_state, exp_state);
    end
    tests++;
    set_in(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_zero();
    apply_reset();
    set_in(1'b1, 1'b1, '0, '0);
    tick();
    if (bus.out_valid !== 1'b1 || bus.out_state !== 128'h0) begin
      fails++; $display("FAIL zero_state got v=%b state=%h want 1 0", bus.out_valid, bus.out_state);
    end
    tests++;
`ifdef SMA_PARITY_EN
    if (bus.out_parity !== 16'h0) begin fails++; $display("FAIL zero_parity got %h want 0", bus.out_parity); end
    tests++;
`endif
    set_in(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom_range(0, 9) < 7,
             (model_rnd == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 15) == 0),
             rand128(), rand128());
      #1;
      exp_rdy = rst || !exp_valid || bus.out_ready;
      if (bus.in_ready !== exp_rdy) begin fails++; $display("FAIL rnd_ready%0d got %b want %b", i, bus.in_ready, exp_rdy); end
      tests++;
      tick();
      if (bus.out_valid !== exp_valid || bus.round_err !== exp_err) begin
        fails++; $display("FAIL rnd_ctl%0d got v=%b err=%b want v=%b err=%b", i, bus.out_valid, bus.round_err, exp_valid, exp_err);
      end
      tests++;
      if (exp_valid) begin
        if (bus.out_state !== exp_state || bus.out_round !== exp_round || bus.out_last !== exp_last) begin
          fails++; $display("FAIL rnd_data%0d got %h r=%0d l=%b want %h r=%0d l=%b", i,
                            bus.out_state, bus.out_round, bus.out_last, exp_state, exp_round, exp_last);
        end
        tests++;
`ifdef SMA_PARITY_EN
        if (bus.out_parity !== byte_parity(exp_state)) begin
          fails++; $display("FAIL rnd_parity%0d got %h want %h", i, bus.out_parity, byte_parity(exp_state));
        end
        tests++;
`endif
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    model_rnd = 0;
    exp_valid = 1'b0;
    exp_state = '0;
    exp_round = '0;
    exp_last  = 1'b0;
    exp_err   = 1'b0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    set_in(1'b0, 1'b0, '0, '0);
    test_reset();
    test_fips_round1();
    test_final_round();
    test_backpressure();
    test_framing();
    test_reset_mid_block();
    test_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_mix_addkey_stage.md
Name: shift_mix_addkey_stage

Overview:
Datapath stage directly downstream of the byte-substitution stage in the AES encryption round. It accepts a substituted 128-bit state plus a round key, then applies ShiftRows, MixColumns and AddRoundKey, with MixColumns skipped on the final round. The result is registered behind a valid/ready handshake. An internal round counter identifies the final round and flags framing errors, so the round controller upstream only marks the first round of each block.

Parameters:
NR, 10, rounds per block (10/12/14 for AES-128/192/256); the final round omits MixColumns
RW, 4, width of round-number output; must satisfy 2^RW > NR

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_state/in_rkey/in_first valid
in_ready  output  1  stage can accept a beat this cycle
in_first  input  1  beat is round 1 of a new block
in_state  input  128  state after SubBytes
in_rkey  input  128  round key for this round
out_valid  output  1  out_* valid
out_ready  input  1  consumer accepts the beat this cycle
out_state  output  128  state after ShiftRows/[MixColumns]/AddRoundKey
out_round  output  RW  round number of out_state (1..NR)
out_last  output  1  out_state is the ciphertext (round == NR)
round_err  output  1  one-cycle pulse on a framing error

Behaviour:
- Byte order (FIPS-197): byte k = in_state[127-8k -: 8], row r = k%4, column c = k/4.
- ShiftRows: out byte (r,c) = in byte (r,(c+r)%4).
- MixColumns: fixed matrix rows {02 03 01 01} circulant; xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0); all XOR, 8-bit results.
- Output state = (round==NR ? ShiftRows(s) : MixColumns(ShiftRows(s))) ^ in_rkey.
- Accept: in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, single output register).
- Latency: 1 cycle from accept to out_valid. Full throughput of one beat per cycle while out_ready=1.
- Output register loads on accept. When out_ready=1 with no accept, out_valid clears next cycle. When out_valid=1 and out_ready=0, out_* stay stable.
- Round counter rnd (RW bits), states IDLE (rnd=0) and BUSY (rnd=1..NR).
- Effective round of an accepted beat is 1 if in_first=1, else rnd+1.
- After an accept, rnd takes the effective round. When the effective round equals NR, rnd returns to 0.
- Framing errors: in_first=0 accepted in IDLE, or in_first=1 accepted in BUSY.
  - Either error raises round_err for one cycle, in the cycle after the accept.
  - The beat is still processed with round 1 (IDLE case) or restarted as round 1 (BUSY case).
- in_first and in_state are ignored while in_valid=0. Only accepted beats affect rnd.
- Reset: out_valid=0, out_state=0, out_round=0, out_last=0, round_err=0, rnd=0.
- Reset mid-block: the in-flight beat is discarded and the next beat must carry in_first.
- in_ready=1 during and after reset.

Optional Feature:
SMA_PARITY_EN.
- Defined: adds output out_parity [15:0]; out_parity[k] = ^out_state byte k (even parity), registered alongside out_state, reset 0.
- Undefined: port absent, no parity logic.

Test Plan:
- FIPS-197 App.B round 1: in_first=1, in_state=d42711aee0bf98f1b8b45de51e415230, in_rkey=a0fafe1788542cb123a339392a6c7605 -> next cycle out_valid=1, out_state=a49c7ff2689f352b6b5bea43026a5049, out_round=1, out_last=0.
- Final round: after 9 beats of one block, beat 10 in_state=e9098972cb31075f3d327d94af2e2cb5, in_rkey=d014f9a8c9ee2589e13f0cc8b6630ca6 -> out_state=3925841d02dc09fbdc118597196a0b32, out_round=10, out_last=1, rnd back to 0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_state stable; release -> back-to-back beats at 1 per cycle, none lost or duplicated, out_round increments 2,3,4.
- Framing: accept in_first=0 after reset -> round_err pulses 1 cycle, out_round=1. Accept in_first=1 at rnd=4 -> round_err pulses, out_round=1.
- Reset mid-block: assert rst at rnd=5 with out_valid=1 -> next cycle out_valid=0, out_round=0. A new in_first beat restarts at round 1 with no round_err.
- All-zero state and key, round 1 -> out_state=0. With SMA_PARITY_EN defined, out_parity=0; round-1 vector above gives out_parity[0]=^8'hA4=1.
